// File: rtl/mem_pkg.sv
// Types shared by the execute and memory stages: memory opcodes, memory-stage
// FSM states and the context captured for one in-flight operation.
package mem_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned REG_W = 4;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_WB   = 2'b11
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  rflags;
    logic [XLEN-1:0]  addr;
    logic [REG_W-1:0] dest;
    mem_op_t          op;
  } mem_ctx_t;

  // Reserved opcode behaves like no memory access.
  function automatic logic is_mem_op(input mem_op_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Load-response watchdog: counts response-less WAIT cycles and flags expiry on
// the TIMEOUT_CYCLES-th one.
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: captures execute results, issues load/store requests, waits
// for load data under a watchdog and produces a one-cycle writeback.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         exe_mem,
  input  logic [127:0] result,
  input  logic [63:0]  rflags,
  input  logic [1:0]   mem_op,
  input  logic [63:0]  mem_addr,
  input  logic [3:0]   dest_reg,
  output logic         mem_blocked,
  output logic         mem_req,
  output logic         mem_req_we,
  output logic [63:0]  mem_req_addr,
  output logic [63:0]  mem_req_data,
  input  logic         mem_req_ack,
  input  logic         mem_resp_valid,
  input  logic [63:0]  mem_resp_data,
  output logic         wb_valid,
  output logic [3:0]   wb_reg,
  output logic [63:0]  wb_data,
  output logic [63:0]  wb_rflags,
  output logic         mem_err
);

  mem_state_t r_state, w_state_next;
  mem_ctx_t   r_ctx, w_ctx_next, w_new_ctx;
  logic       r_err, w_err_next;
  logic       w_capture;
  logic       w_wd_clear, w_wd_enable, w_wd_expired;
  logic       w_unused_result_hi;

  assign w_unused_result_hi = ^result[127:64];

  always_comb begin
    w_new_ctx        = '0;
    w_new_ctx.data   = result[63:0];
    w_new_ctx.rflags = rflags;
    w_new_ctx.addr   = mem_addr;
    w_new_ctx.dest   = dest_reg;
    w_new_ctx.op     = mem_op_t'(mem_op);
  end

  assign mem_blocked = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_capture   = exe_mem && !mem_blocked &&
                       ((r_state == ST_IDLE) || (r_state == ST_WB));
  assign w_wd_enable = (r_state == ST_WAIT) && !mem_resp_valid;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ctx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ctx   <= w_ctx_next;
      r_err   <= w_err_next;
    end
  end

  // Next state; load data overwrites the captured result so WB has one source.
  always_comb begin
    w_state_next = r_state;
    w_ctx_next   = r_ctx;
    w_err_next   = r_err;
    w_wd_clear   = 1'b0;
    case (r_state)
      ST_IDLE, ST_WB: begin
        if (r_state == ST_WB) begin
          w_state_next = ST_IDLE;
        end
        if (w_capture) begin
          w_ctx_next   = w_new_ctx;
          w_state_next = is_mem_op(w_new_ctx.op) ? ST_REQ : ST_WB;
        end
      end
      ST_REQ: begin
        if (mem_req_ack) begin
          if (r_ctx.op == OP_STORE) begin
            w_state_next = ST_IDLE;
          end else if (mem_resp_valid) begin
            w_ctx_next.data = mem_resp_data;
            w_state_next    = ST_WB;
          end else begin
            w_wd_clear   = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          w_ctx_next.data = mem_resp_data;
          w_state_next    = ST_WB;
        end else if (w_wd_expired) begin
          w_err_next   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Payload outputs are forced to zero whenever their qualifier is low.
  assign mem_req      = (r_state == ST_REQ);
  assign mem_req_we   = mem_req && (r_ctx.op == OP_STORE);
  assign mem_req_addr = mem_req ? r_ctx.addr : '0;
  assign mem_req_data = mem_req ? r_ctx.data : '0;

  assign wb_valid  = (r_state == ST_WB);
  assign wb_reg    = wb_valid ? r_ctx.dest   : '0;
  assign wb_data   = wb_valid ? r_ctx.data   : '0;
  assign wb_rflags = wb_valid ? r_ctx.rflags : '0;

  assign mem_err = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks plus a writeback
// scoreboard (expected pushed at stimulus, observed pushed by a monitor).
module tb_mem_stage;

  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic [3:0]  r;
    logic [63:0] d;
    logic [63:0] f;
  } wb_exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          exe_mem;
  logic [127:0]  result;
  logic [63:0]   rflags;
  logic [1:0]    mem_op;
  logic [63:0]   mem_addr;
  logic [3:0]    dest_reg;
  logic          mem_blocked;
  logic          mem_req;
  logic          mem_req_we;
  logic [63:0]   mem_req_addr;
  logic [63:0]   mem_req_data;
  logic          mem_req_ack;
  logic          mem_resp_valid;
  logic [63:0]   mem_resp_data;
  logic          wb_valid;
  logic [3:0]    wb_reg;
  logic [63:0]   wb_data;
  logic [63:0]   wb_rflags;
  logic          mem_err;

  wb_exp_t exp_q[$];
  wb_exp_t obs_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int wb_seen = 0;

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .exe_mem        (exe_mem),
    .result         (result),
    .rflags         (rflags),
    .mem_op         (mem_op),
    .mem_addr       (mem_addr),
    .dest_reg       (dest_reg),
    .mem_blocked    (mem_blocked),
    .mem_req        (mem_req),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_ack    (mem_req_ack),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .wb_valid       (wb_valid),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .wb_rflags      (wb_rflags),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  // Writeback monitor feeding the observed side of the scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wb_valid === 1'b1) begin
      obs_q.push_back(wb_exp_t'({wb_reg, wb_data, wb_rflags}));
      wb_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic idle_inputs();
    exe_mem        = 1'b0;
    result         = '0;
    rflags         = '0;
    mem_op         = 2'b00;
    mem_addr       = '0;
    dest_reg       = '0;
    mem_req_ack    = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    exe_mem = 1'b1; mem_op = 2'b01; mem_addr = 64'hABCD;
    mem_req_ack = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h77;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({mem_req, mem_req_we, wb_valid, mem_err, mem_blocked} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req/we/wb/err/blk=%b, required 00000",
               {mem_req, mem_req_we, wb_valid, mem_err, mem_blocked});
    end
    n_tests++;
    if ({mem_req_addr, mem_req_data, wb_data, wb_rflags, wb_reg} !== 260'b0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h data=%h wbd=%h wbf=%h wbr=%h, required all 0",
               mem_req_addr, mem_req_data, wb_data, wb_rflags, wb_reg);
    end
    idle_inputs();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nonmem();
    wb_exp_t o, e;
    int base = wb_seen;
    exe_mem = 1'b1; mem_op = 2'b00; dest_reg = 4'd3; rflags = 64'h46;
    result = {64'hFFFF_0000_FFFF_0000, 64'h1234};
    exp_q.push_back(wb_exp_t'({4'd3, 64'h1234, 64'h46}));
    @(negedge clk);
    n_tests++;
    if ({wb_valid, mem_blocked} !== 2'b10) begin
      n_fail++;
      $display("FAIL nonmem_wb1: got wb_valid/blocked=%b, required 10", {wb_valid, mem_blocked});
    end
    mem_op = 2'b11; dest_reg = 4'd5; rflags = 64'h1; result = 128'h77;
    exp_q.push_back(wb_exp_t'({4'd5, 64'h77, 64'h1}));
    @(negedge clk);
    n_tests++;
    if ({wb_valid, mem_blocked, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL nonmem_b2b: got wb_valid/blocked/req=%b, required 100",
               {wb_valid, mem_blocked, mem_req});
    end
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if ({wb_valid, mem_blocked, wb_data} !== 66'b0) begin
      n_fail++;
      $display("FAIL nonmem_idle: got wb_valid=%b blocked=%b wb_data=%h, required 0 0 0",
               wb_valid, mem_blocked, wb_data);
    end
    @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL nonmem_sb: got wb %h, required none", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL nonmem_sb: got wb %h, required %h", o, e); end
      end
    end
    n_tests++;
    if (wb_seen - base !== 2) begin
      n_fail++; $display("FAIL nonmem_count: got %0d writebacks, required 2", wb_seen - base);
    end
  endtask

  task automatic test_load();
    wb_exp_t o, e;
    int base = wb_seen;
    exe_mem = 1'b1; mem_op = 2'b01; mem_addr = 64'h1000; dest_reg = 4'd7;
    rflags = 64'h11; result = 128'h999;
    exp_q.push_back(wb_exp_t'({4'd7, 64'hDEADBEEF, 64'h11}));
    @(negedge clk);
    // A held non-memory op waits behind the load.
    mem_op = 2'b00; mem_addr = '0; dest_reg = 4'd2; rflags = 64'h22; result = 128'hABC;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({mem_req, mem_blocked, mem_req_we, mem_req_addr} !== {3'b110, 64'h1000}) begin
        n_fail++;
        $display("FAIL load_req%0d: got req/blk/we=%b addr=%h, required 110 1000",
                 i, {mem_req, mem_blocked, mem_req_we}, mem_req_addr);
      end
      if (i == 1) mem_req_ack = 1'b1;
      @(negedge clk);
    end
    mem_req_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({mem_req, mem_blocked, wb_valid} !== 3'b010) begin
        n_fail++;
        $display("FAIL load_wait%0d: got req/blk/wb=%b, required 010",
                 i, {mem_req, mem_blocked, wb_valid});
      end
      if (i == 2) begin mem_resp_valid = 1'b1; mem_resp_data = 64'hDEADBEEF; end
      @(negedge clk);
    end
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    n_tests++;
    if ({wb_valid, mem_blocked} !== 2'b10) begin
      n_fail++;
      $display("FAIL load_wb: got wb_valid/blocked=%b, required 10", {wb_valid, mem_blocked});
    end
    exp_q.push_back(wb_exp_t'({4'd2, 64'hABC, 64'h22}));
    @(negedge clk);
    n_tests++;
    if (wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL load_held_wb: got wb_valid=%b, required 1", wb_valid);
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL load_sb: got wb %h, required none", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL load_sb: got wb %h, required %h", o, e); end
      end
    end
    n_tests++;
    if (wb_seen - base !== 2) begin
      n_fail++; $display("FAIL load_count: got %0d writebacks, required 2", wb_seen - base);
    end
  endtask

  task automatic test_store();
    int base = wb_seen;
    exe_mem = 1'b1; mem_op = 2'b10; mem_addr = 64'h2000; dest_reg = 4'd4;
    rflags = 64'h9; result = 128'h55; mem_req_ack = 1'b1;
    @(negedge clk);
    exe_mem = 1'b0;
    n_tests++;
    if ({mem_req, mem_req_we, mem_blocked, mem_req_addr, mem_req_data} !==
        {3'b111, 64'h2000, 64'h55}) begin
      n_fail++;
      $display("FAIL store_req: got req/we/blk=%b addr=%h data=%h, required 111 2000 55",
               {mem_req, mem_req_we, mem_blocked}, mem_req_addr, mem_req_data);
    end
    @(negedge clk);
    mem_req_ack = 1'b0;
    n_tests++;
    if ({mem_req, mem_req_we, mem_blocked, wb_valid, mem_req_data} !== 68'b0) begin
      n_fail++;
      $display("FAIL store_idle: got req/we/blk/wb=%b data=%h, required 0000 0",
               {mem_req, mem_req_we, mem_blocked, wb_valid}, mem_req_data);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    n_tests++;
    if (wb_seen !== base) begin
      n_fail++; $display("FAIL store_nowb: got %0d writebacks, required 0", wb_seen - base);
    end
  endtask

  task automatic test_ack_resp();
    wb_exp_t o, e;
    exe_mem = 1'b1; mem_op = 2'b01; mem_addr = 64'h3000; dest_reg = 4'd9; rflags = 64'h5;
    result = 128'h1; mem_req_ack = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'hCAFE;
    exp_q.push_back(wb_exp_t'({4'd9, 64'hCAFE, 64'h5}));
    @(negedge clk);
    exe_mem = 1'b0;
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL ackresp_req: got mem_req=%b, required 1", mem_req);
    end
    @(negedge clk);
    mem_req_ack = 1'b0; mem_resp_valid = 1'b0;
    n_tests++;
    if ({wb_valid, mem_blocked} !== 2'b10) begin
      n_fail++;
      $display("FAIL ackresp_wb: got wb_valid/blocked=%b, required 10", {wb_valid, mem_blocked});
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL ackresp_sb: got wb %h, required none", o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL ackresp_sb: got wb %h, required %h", o, e); end
      end
    end
  endtask

  task automatic test_timeout();
    int base = wb_seen;
    exe_mem = 1'b1; mem_op = 2'b01; mem_addr = 64'h4000; dest_reg = 4'd1; mem_req_ack = 1'b1;
    @(negedge clk);
    exe_mem = 1'b0;
    @(negedge clk);
    mem_req_ack = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      n_tests++;
      if ({mem_blocked, mem_err} !== 2'b10) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: got blocked/err=%b, required 10", i, {mem_blocked, mem_err});
      end
      @(negedge clk);
    end
    n_tests++;
    if ({mem_err, mem_blocked, wb_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL timeout_expire: got err/blk/wb=%b, required 100",
               {mem_err, mem_blocked, wb_valid});
    end
    @(negedge clk);
    n_tests++;
    if (mem_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got mem_err=%b, required 1", mem_err);
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: got mem_err=%b, required 0", mem_err);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wb_seen !== base) begin
      n_fail++; $display("FAIL timeout_nowb: got %0d writebacks, required 0", wb_seen - base);
    end
  endtask

  task automatic test_reset_wait();
    int base = wb_seen;
    exe_mem = 1'b1; mem_op = 2'b01; mem_addr = 64'h5000; dest_reg = 4'd6; mem_req_ack = 1'b1;
    @(negedge clk);
    exe_mem = 1'b0;
    @(negedge clk);
    mem_req_ack = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_blocked} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstwait_drop: got req/blocked=%b, required 00", {mem_req, mem_blocked});
    end
    reset_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({wb_valid, mem_req, mem_blocked} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstwait_late%0d: got wb/req/blk=%b, required 000",
                 i, {wb_valid, mem_req, mem_blocked});
      end
    end
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if (wb_seen !== base) begin
      n_fail++; $display("FAIL rstwait_nowb: got %0d writebacks, required 0", wb_seen - base);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load();
    test_store();
    test_ack_resp();
    test_timeout();
    test_reset_wait();
    n_tests++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected and %0d observed left, required 0 0",
               exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of WAIT cycles before an access is abandoned; the stage SHALL honour it.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  in  1  reset; synchronous and active-low.
REQ-004 exe_mem  in  1  execute-stage output valid.
REQ-005 result  in  128  execute result; bits [63:0] SHALL be used.
REQ-006 rflags  in  64  execute flags.
REQ-007 mem_op  in  2  operation: 00 none, 01 load, 10 store, 11 reserved (treated as none).
REQ-008 mem_addr  in  64  load/store address.
REQ-009 dest_reg  in  4  writeback GPR index.
REQ-010 mem_blocked  out  1  stall to execute stage.
REQ-011 mem_req, mem_req_we, mem_req_addr[63:0], mem_req_data[63:0]  out  memory request, write enable, address, store data.
REQ-012 mem_req_ack  in  1  request accepted.
REQ-013 mem_resp_valid, mem_resp_data[63:0]  in  load response valid and data.
REQ-014 wb_valid, wb_reg[3:0], wb_data[63:0], wb_rflags[63:0]  out  writeback to register file and flags.
REQ-015 mem_err  out  1  sticky timeout error.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT and WB.
REQ-017 mem_blocked SHALL be combinational and SHALL equal (state==REQ || state==WAIT).
REQ-018 The stage SHALL capture result[63:0], rflags, mem_op, mem_addr and dest_reg only when exe_mem && !mem_blocked, in IDLE or WB.
REQ-019 On capture with op none, the next state SHALL be WB: wb_valid=1 one cycle after capture, with wb_data=result[63:0].
REQ-020 On capture with op load or store, the next state SHALL be REQ.
REQ-021 In REQ, mem_req=1, mem_req_addr=captured addr, mem_req_we=(op==store), mem_req_data=captured result[63:0], all held stable until mem_req_ack.
REQ-022 REQ with ack, store: next state SHALL be IDLE; no writeback occurs.
REQ-023 REQ with ack, load: next state SHALL be WAIT, unless mem_resp_valid is also 1 that cycle, in which case the next state SHALL be WB with the response data latched.
REQ-024 WAIT with mem_resp_valid: latch mem_resp_data; next state SHALL be WB.
REQ-025 Watchdog: a counter SHALL clear on entry to WAIT and increment each WAIT cycle without a response.
REQ-026 Watchdog expiry: when the count reaches TIMEOUT_CYCLES, mem_err SHALL set, the access SHALL be abandoned, and the next state SHALL be IDLE with no writeback.
REQ-027 mem_resp_valid outside WAIT, and outside the REQ-with-ack case of REQ-023, SHALL be ignored.
REQ-028 WB: wb_valid=1 for exactly one cycle; wb_reg=captured dest_reg; wb_rflags=captured rflags; wb_data=load data or result[63:0].
REQ-029 WB with a new capture: the next state SHALL follow REQ-019/020 (back-to-back ops); otherwise the next state SHALL be IDLE.
REQ-030 All non-listed outputs SHALL be 0 whenever wb_valid or mem_req is 0.
REQ-031 Throughput: one non-memory op per cycle; a load SHALL occupy at least 3 cycles (capture, REQ, WB).

Reset
REQ-032 reset_n=0 at a clock edge SHALL force IDLE and clear the watchdog; mem_req, wb_valid, mem_err, mem_blocked and all data outputs SHALL read 0 from the next cycle.
REQ-033 Reset mid-access SHALL drop the outstanding request; a late response after reset SHALL be ignored.

Structure
REQ-034 mem_op_t and the state enum SHALL live in shared package mem_pkg, imported by execute and memory stages.
REQ-035 The watchdog SHALL be sub-module mem_watchdog, with parameter TIMEOUT_CYCLES and ports clear, enable and expired.

Verification
REQ-036 Op none, result=0x1234, dest=3, rflags=0x46: wb_valid the next cycle with wb_reg=3, wb_data=0x1234, wb_rflags=0x46; mem_blocked never 1.
REQ-037 Load addr=0x1000, ack after 2 cycles, response 3 cycles later with 0xDEADBEEF: mem_blocked held throughout; one wb_valid with data 0xDEADBEEF; the held execute op is captured in the WB cycle.
REQ-038 Store addr=0x2000, data=0x55, ack same cycle as REQ: mem_req_we=1 for 1 cycle; no wb_valid; state IDLE after.
REQ-039 Load with ack and resp in the same cycle: WB the next cycle with the response data; WAIT never entered.
REQ-040 Load with no response and TIMEOUT_CYCLES=4: mem_err=1 after 4 WAIT cycles, no wb_valid; reset_n=0 clears mem_err.
REQ-041 reset_n=0 during WAIT, then mem_resp_valid: mem_req=0, wb_valid stays 0.
